// File: rtl/regbank_pkg.sv
// regbank_pkg: shared state encoding, default widths and the hardwired-zero register index.
package regbank_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 5;
  localparam logic [ADDR_W_DEF-1:0] ZERO_REG = 5'd0;
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_A = 3'd1,
    RD_B = 3'd2,
    EXEC = 3'd3,
    WB   = 3'd4
  } state_t;
endpackage

// File: rtl/regbank_seq_if.sv
// regbank_seq_if: decoder, ALU and register-bank signals of the sequencer.
interface regbank_seq_if import regbank_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) ();
  logic              start;
  logic [ADDR_W-1:0] rs1;
  logic [ADDR_W-1:0] rs2;
  logic [ADDR_W-1:0] rd;
  logic              wr_en;
  logic              busy;
  logic              ops_valid;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] result;
  logic              result_valid;
  logic              done;
  logic              err;
  logic [ADDR_W-1:0] rb_sel;
  logic [DATA_W-1:0] rb_data_in;
  logic              rb_write;
  logic [DATA_W-1:0] rb_data_out;
  modport slave (
    input  start, rs1, rs2, rd, wr_en, result, result_valid, rb_data_out,
    output busy, ops_valid, op_a, op_b, done, err, rb_sel, rb_data_in, rb_write
  );
  modport master (
    output start, rs1, rs2, rd, wr_en, result, result_valid, rb_data_out,
    input  busy, ops_valid, op_a, op_b, done, err, rb_sel, rb_data_in, rb_write
  );
endinterface

// File: rtl/regbank_seq_exec_watchdog.sv
// exec_watchdog: saturating EXEC-cycle timer that flags expiry at TIMEOUT-1 (TIMEOUT=0 disables it).
module exec_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int W = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en && cnt != '1) cnt <= cnt + 1'b1;
  assign expire = (TIMEOUT != 0) && (cnt == W'(TIMEOUT - 1));
endmodule

// File: rtl/regbank_seq.sv
// regbank_seq: reads two operands through the single-port bank, hands them to the ALU,
// waits for the result and writes it back unless the destination is r0.
module regbank_seq import regbank_pkg::*; #(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int TIMEOUT = 64
) (
  input logic          clk,
  input logic          rst_n,
  regbank_seq_if.slave bus
);
  state_t            state, state_n;
  logic [ADDR_W-1:0] rs1_q, rs2_q, rd_q;
  logic              wr_en_q;
  logic [DATA_W-1:0] result_q;
  logic              done_n, err_n, expire, wb_go;
  exec_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (state != EXEC),
    .en     (state == EXEC && !bus.result_valid),
    .expire (expire)
  );
  assign wb_go = wr_en_q && rd_q != ADDR_W'(ZERO_REG);
  always_comb begin
    state_n = state;
    done_n  = 1'b0;
    err_n   = 1'b0;
    case (state)
      IDLE: state_n = bus.start ? RD_A : IDLE;
      RD_A: state_n = RD_B;
      RD_B: state_n = EXEC;
      EXEC: begin
        // a result arriving on the expiry cycle still completes normally
        if (bus.result_valid) begin
          state_n = wb_go ? WB : IDLE;
          done_n  = !wb_go;
        end else if (expire) begin
          state_n = IDLE;
          err_n   = 1'b1;
        end
      end
      WB: begin
        state_n = IDLE;
        done_n  = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state         <= IDLE;
      rs1_q         <= '0;
      rs2_q         <= '0;
      rd_q          <= '0;
      wr_en_q       <= 1'b0;
      result_q      <= '0;
      bus.op_a      <= '0;
      bus.op_b      <= '0;
      bus.ops_valid <= 1'b0;
      bus.done      <= 1'b0;
      bus.err       <= 1'b0;
    end else begin
      state         <= state_n;
      bus.ops_valid <= state == RD_B;
      bus.done      <= done_n;
      bus.err       <= err_n;
      if (state == IDLE && bus.start) begin
        rs1_q   <= bus.rs1;
        rs2_q   <= bus.rs2;
        rd_q    <= bus.rd;
        wr_en_q <= bus.wr_en;
      end
      if (state == RD_A) bus.op_a <= bus.rb_data_out;
      if (state == RD_B) bus.op_b <= bus.rb_data_out;
      if (state == EXEC && bus.result_valid) result_q <= bus.result;
    end
  // bank controls come straight from the state register so reset removes rb_write at once
  assign bus.busy       = state != IDLE;
  assign bus.rb_write   = state == WB;
  assign bus.rb_sel     = state == RD_A ? rs1_q : state == RD_B ? rs2_q : state == WB ? rd_q : '0;
  assign bus.rb_data_in = state == WB ? result_q : '0;
endmodule
